// File: rtl/uart_tx_cfg_if.sv
// Producer-side handshake between the UART register block and the transmitter.
// The register block drives the write strobe and byte; the transmitter reports FIFO space.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  logic                          i_Tx_DV;
  logic [DATA_BITS-1:0]          i_Tx_Byte;
  logic                          o_Tx_Ready;
  logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count;

  modport master (output i_Tx_DV, i_Tx_Byte, input o_Tx_Ready, o_Fifo_Count);
  modport slave  (input i_Tx_DV, i_Tx_Byte, output o_Tx_Ready, o_Fifo_Count);
endinterface

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: runtime divisor, per-frame parity/stop selection,
// and a small input FIFO so the register block can queue bytes back to back.
//
// state  | meaning
// IDLE   | line high; pop next byte and latch frame configuration when FIFO non-empty
// START  | start bit (0) for one bit time
// DATA   | data bits, LSB first
// PARITY | even / odd / mark parity bit
// STOP   | one or two stop bits (1)
// DONE   | one-cycle end-of-frame marker, then back to IDLE
module uart_tx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  uart_tx_cfg_if.slave     tx_if,
  input  logic [DIV_W-1:0] i_Clks_Per_Bit,
  input  logic [1:0]       i_Parity_Mode,
  input  logic             i_Two_Stop,
  output logic             o_Tx_Active,
  output logic             o_Tx_Serial,
  output logic             o_Tx_Done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     bit_cnt_q, bit_cnt_d, cpb_q, cpb_d, cpb_in, bit_nxt;
  logic [1:0]           mode_q, mode_d;
  logic                 two_q, two_d, stop_q, stop_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 serial_q, serial_d, active_q, active_d, done_q, done_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 wr, pop, ready, bit_last, par_bit;

  assign ready    = (count_q != CW'(FIFO_DEPTH));
  assign wr       = tx_if.i_Tx_DV && ready;
  assign cpb_in   = (i_Clks_Per_Bit < DIV_W'(2)) ? DIV_W'(2) : i_Clks_Per_Bit;
  assign bit_last = (bit_cnt_q == cpb_q - DIV_W'(1));
  assign bit_nxt  = bit_last ? '0 : bit_cnt_q + DIV_W'(1);
  assign par_bit  = (mode_q == 2'b11) ? 1'b1 : ((^data_q) ^ (mode_q == 2'b10));

  assign tx_if.o_Tx_Ready   = ready;
  assign tx_if.o_Fifo_Count = count_q;
  assign o_Tx_Serial        = serial_q;
  assign o_Tx_Active        = active_q;
  assign o_Tx_Done          = done_q;

  // A write and a pop on the same edge cancel; full-FIFO writes are simply dropped.
  always_comb begin
    wr_ptr_d = wr  ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({wr, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (wr) mem_q[wr_ptr_q] <= tx_if.i_Tx_Byte;
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    idx_d     = idx_q;
    stop_d    = stop_q;
    data_d    = data_q;
    cpb_d     = cpb_q;
    mode_d    = mode_q;
    two_d     = two_q;
    pop       = 1'b0;
    serial_d  = 1'b1;
    active_d  = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          data_d    = mem_q[rd_ptr_q];
          cpb_d     = cpb_in;
          mode_d    = i_Parity_Mode;
          two_d     = i_Two_Stop;
          bit_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        serial_d  = 1'b0;
        active_d  = 1'b1;
        bit_cnt_d = bit_nxt;
        if (bit_last) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        serial_d  = data_q[idx_q];
        active_d  = 1'b1;
        bit_cnt_d = bit_nxt;
        if (bit_last) begin
          if (idx_q == IW'(DATA_BITS - 1)) begin
            stop_d  = 1'b0;
            state_d = (mode_q != 2'b00) ? PARITY : STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      PARITY: begin
        serial_d  = par_bit;
        active_d  = 1'b1;
        bit_cnt_d = bit_nxt;
        if (bit_last) begin
          stop_d  = 1'b0;
          state_d = STOP;
        end
      end
      STOP: begin
        active_d  = 1'b1;
        bit_cnt_d = bit_nxt;
        if (bit_last) begin
          if (two_q && !stop_q) stop_d  = 1'b1;
          else                  state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line, active and done are registered from the current state, so all three
  // lag the state by one cycle and stay aligned with each other.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      cpb_q     <= DIV_W'(2);
      mode_q    <= 2'b00;
      two_q     <= 1'b0;
      stop_q    <= 1'b0;
      idx_q     <= '0;
      data_q    <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      cpb_q     <= cpb_d;
      mode_q    <= mode_d;
      two_q     <= two_d;
      stop_q    <= stop_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: an 8-bit and a 5-bit instance share clock,
// reset and frame configuration; each has its own producer interface.
module tb_uart_tx_cfg;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpb = 16'd4;
  logic [1:0]  mode = 2'b00;
  logic        two = 1'b0;
  logic        act8, ser8, done8, act5, ser5, done5;
  int          checks = 0;
  int          failures = 0;

  uart_tx_cfg_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus8 ();
  uart_tx_cfg_if #(.DATA_BITS(5), .FIFO_DEPTH(4)) bus5 ();

  uart_tx_cfg #(.DATA_BITS(8), .DIV_W(16), .FIFO_DEPTH(4)) u8 (
    .i_Clock(clk), .i_Reset(rst), .tx_if(bus8),
    .i_Clks_Per_Bit(cpb), .i_Parity_Mode(mode), .i_Two_Stop(two),
    .o_Tx_Active(act8), .o_Tx_Serial(ser8), .o_Tx_Done(done8));

  uart_tx_cfg #(.DATA_BITS(5), .DIV_W(16), .FIFO_DEPTH(4)) u5 (
    .i_Clock(clk), .i_Reset(rst), .tx_if(bus5),
    .i_Clks_Per_Bit(cpb), .i_Parity_Mode(mode), .i_Two_Stop(two),
    .o_Tx_Active(act5), .o_Tx_Serial(ser5), .o_Tx_Done(done5));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cpb;
    int          eff;
    logic [1:0]  mode;
    logic        two;
    logic [7:0]  data;
    bit          is5;
    logic [11:0] pat;   // line bits, bit 0 = start bit
    int          nbits;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
    end
  endtask

  function automatic int mk_pat(input logic [7:0] d, input int dbits, input logic [1:0] m,
                                input logic tw, output logic [11:0] p);
    int  i;
    logic x;
    p = '0;
    x = 1'b0;
    i = 1;
    for (int b = 0; b < dbits; b++) begin
      p[i] = d[b];
      x    = x ^ d[b];
      i++;
    end
    if (m != 2'b00) begin
      p[i] = (m == 2'b01) ? x : (m == 2'b10) ? ~x : 1'b1;
      i++;
    end
    p[i] = 1'b1;
    i++;
    if (tw) begin
      p[i] = 1'b1;
      i++;
    end
    return i;
  endfunction

  // Called in the first start-bit cycle; returns in the cycle after the two mark cycles.
  task automatic run_frame(input logic [11:0] pat, input int n, input int eff, input bit is5,
                           input int exp_cnt, input string tag);
    logic [2:0] obs;
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < eff; c++) begin
        obs = is5 ? {ser5, act5, done5} : {ser8, act8, done8};
        chk($sformatf("%s bit%0d cyc%0d {line,act,done}", tag, b, c), obs, {pat[b], 2'b10});
        @(negedge clk);
      end
    end
    obs = is5 ? {ser5, act5, done5} : {ser8, act8, done8};
    chk({tag, " mark1 {line,act,done}"}, obs, 3'b101);
    @(negedge clk);
    obs = is5 ? {ser5, act5, done5} : {ser8, act8, done8};
    chk({tag, " mark2 {line,act,done}"}, obs, 3'b100);
    chk({tag, " mark2 count"}, is5 ? bus5.o_Fifo_Count : bus8.o_Fifo_Count, exp_cnt);
    @(negedge clk);
  endtask

  task automatic watch_idle(input int cycles, input string tag);
    int bad = 0;
    for (int i = 0; i < cycles; i++) begin
      if (ser8 !== 1'b1 || done8 !== 1'b0 || act8 !== 1'b0) bad++;
      @(negedge clk);
    end
    chk({tag, " non-idle cycles"}, bad, 0);
  endtask

  initial begin
    logic [11:0] p;
    int          n;
    logic [7:0]  bytes [6];

    vecs[0] = '{16'd4, 4, 2'b00, 1'b0, 8'hA5, 1'b0, 12'h34A, 10};
    vecs[1] = '{16'd3, 3, 2'b01, 1'b0, 8'h07, 1'b0, 12'h60E, 11};
    vecs[2] = '{16'd3, 3, 2'b10, 1'b0, 8'h07, 1'b0, 12'h40E, 11};
    vecs[3] = '{16'd3, 3, 2'b11, 1'b0, 8'h07, 1'b0, 12'h60E, 11};
    vecs[4] = '{16'd0, 2, 2'b00, 1'b0, 8'h3C, 1'b0, 12'h278, 10};
    vecs[5] = '{16'd1, 2, 2'b00, 1'b0, 8'h3C, 1'b0, 12'h278, 10};
    vecs[6] = '{16'd2, 2, 2'b10, 1'b1, 8'hA5, 1'b0, 12'hF4A, 12};
    vecs[7] = '{16'd3, 3, 2'b00, 1'b0, 8'h1F, 1'b1, 12'h07E, 7};
    vecs[8] = '{16'd2, 2, 2'b01, 1'b0, 8'h15, 1'b1, 12'h0EA, 8};

    bus8.i_Tx_DV = 1'b0; bus8.i_Tx_Byte = '0;
    bus5.i_Tx_DV = 1'b0; bus5.i_Tx_Byte = '0;

    repeat (3) @(negedge clk);
    chk("reset8 {line,act,done,ready,count}", {ser8, act8, done8, bus8.o_Tx_Ready, bus8.o_Fifo_Count}, 7'b1001000);
    chk("reset5 {line,act,done,ready,count}", {ser5, act5, done5, bus5.o_Tx_Ready, bus5.o_Fifo_Count}, 7'b1001000);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single frames: timing, parity modes, divisor clamp, two stops, 5-bit width.
    for (int v = 0; v < 9; v++) begin
      cpb = vecs[v].cpb; mode = vecs[v].mode; two = vecs[v].two;
      if (vecs[v].is5) begin bus5.i_Tx_DV = 1'b1; bus5.i_Tx_Byte = vecs[v].data[4:0]; end
      else             begin bus8.i_Tx_DV = 1'b1; bus8.i_Tx_Byte = vecs[v].data; end
      @(negedge clk);
      bus8.i_Tx_DV = 1'b0; bus5.i_Tx_DV = 1'b0;
      chk($sformatf("v%0d count after write", v), vecs[v].is5 ? bus5.o_Fifo_Count : bus8.o_Fifo_Count, 1);
      @(negedge clk);
      chk($sformatf("v%0d line before start", v), vecs[v].is5 ? ser5 : ser8, 1'b1);
      @(negedge clk);
      run_frame(vecs[v].pat, vecs[v].nbits, vecs[v].eff, vecs[v].is5, 0, $sformatf("v%0d", v));
      repeat (2) @(negedge clk);
    end

    // Back-to-back with two stop bits.
    cpb = 16'd4; mode = 2'b00; two = 1'b1;
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
    bus8.i_Tx_DV = 1'b1; bus8.i_Tx_Byte = bytes[0];
    @(negedge clk);
    chk("b2b count c0", bus8.o_Fifo_Count, 1);
    bus8.i_Tx_Byte = bytes[1];
    @(negedge clk);
    chk("b2b count c1", bus8.o_Fifo_Count, 1);
    bus8.i_Tx_Byte = bytes[2];
    @(negedge clk);
    bus8.i_Tx_DV = 1'b0;
    chk("b2b count c2", bus8.o_Fifo_Count, 2);
    for (int f = 0; f < 3; f++) begin
      n = mk_pat(bytes[f], 8, 2'b00, 1'b1, p);
      run_frame(p, n, 4, 1'b0, (f == 0) ? 1 : 0, $sformatf("b2b f%0d", f));
    end
    watch_idle(10, "b2b tail");

    // FIFO full: six writes, the sixth dropped.
    cpb = 16'd100; two = 1'b0; mode = 2'b00;
    bytes[0] = 8'h81; bytes[1] = 8'h42; bytes[2] = 8'h24;
    bytes[3] = 8'h18; bytes[4] = 8'hC3; bytes[5] = 8'h3C;
    bus8.i_Tx_DV = 1'b1; bus8.i_Tx_Byte = bytes[0];
    @(negedge clk);
    bus8.i_Tx_Byte = bytes[1];
    @(negedge clk);
    bus8.i_Tx_Byte = bytes[2];
    @(negedge clk);
    bus8.i_Tx_Byte = bytes[3];
    n = mk_pat(bytes[0], 8, 2'b00, 1'b0, p);
    fork
      run_frame(p, n, 100, 1'b0, 3, "full f0");
      begin
        @(negedge clk);
        chk("full ready at 3", bus8.o_Tx_Ready, 1'b1);
        bus8.i_Tx_Byte = bytes[4];
        @(negedge clk);
        chk("full ready at 4", bus8.o_Tx_Ready, 1'b0);
        chk("full count at 4", bus8.o_Fifo_Count, 4);
        bus8.i_Tx_Byte = bytes[5];
        @(negedge clk);
        bus8.i_Tx_DV = 1'b0;
        chk("full count after drop", bus8.o_Fifo_Count, 4);
      end
    join
    for (int f = 1; f < 5; f++) begin
      n = mk_pat(bytes[f], 8, 2'b00, 1'b0, p);
      run_frame(p, n, 100, 1'b0, (f < 4) ? 3 - f : 0, $sformatf("full f%0d", f));
    end
    watch_idle(300, "full no sixth frame");

    // Divisor change mid-frame applies only to the next frame.
    cpb = 16'd4; mode = 2'b00; two = 1'b0;
    bus8.i_Tx_DV = 1'b1; bus8.i_Tx_Byte = 8'h5A;
    @(negedge clk);
    bus8.i_Tx_DV = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n = mk_pat(8'h5A, 8, 2'b00, 1'b0, p);
    fork
      run_frame(p, n, 4, 1'b0, 0, "recfg f0");
      begin
        repeat (6) @(negedge clk);
        cpb = 16'd8;
        bus8.i_Tx_DV = 1'b1; bus8.i_Tx_Byte = 8'h5B;
        @(negedge clk);
        bus8.i_Tx_DV = 1'b0;
      end
    join
    n = mk_pat(8'h5B, 8, 2'b00, 1'b0, p);
    run_frame(p, n, 8, 1'b0, 0, "recfg f1");

    // Reset during DATA aborts the frame and empties the FIFO.
    cpb = 16'd4;
    bus8.i_Tx_DV = 1'b1; bus8.i_Tx_Byte = 8'h00;
    @(negedge clk);
    @(negedge clk);
    bus8.i_Tx_DV = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst pre {line,act,count}", {ser8, act8, bus8.o_Fifo_Count}, 5'b01001);
    #2 rst = 1'b1;
    #1 chk("rst async {line,act,done,ready,count}", {ser8, act8, done8, bus8.o_Tx_Ready, bus8.o_Fifo_Count}, 7'b1001000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst held done", done8, 1'b0);
    end
    rst = 1'b0;
    watch_idle(40, "after reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
